alu_seq: RTL

Parametrised successor to the combinational ALU-control decoder: it decodes `i_op`/`i_func` using the `OP_*`/`FUNC_*` macros in defs.v, and it also executes the operation. Single-cycle operations complete in one clock. MUL, DIV and MOD run on an iterative shift/add or restoring datapath behind a start/busy/done handshake. It sits in the execute stage; the pipeline stalls on `o_busy`.

---
 rtl/alu_seq.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: ALU-control decoder plus execute unit. Single-cycle ops finish in one
// clock; MUL (shift/add) and signed DIV/MOD (restoring) iterate W steps behind a
// start/busy/done handshake.
module alu_seq #(
    parameter int unsigned W    = 32,
    parameter int unsigned SH_W = $clog2(W)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [9:0]   i_func,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_zero,
    output logic         o_divz
);

    localparam int unsigned CW = $clog2(W);

    // Opcode / function encodings (mirrors defs.v).
    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [9:0] FUNC_ADD  = 10'd1;
    localparam logic [9:0] FUNC_SUB  = 10'd2;
    localparam logic [9:0] FUNC_AND  = 10'd3;
    localparam logic [9:0] FUNC_OR   = 10'd4;
    localparam logic [9:0] FUNC_XOR  = 10'd5;
    localparam logic [9:0] FUNC_NOR  = 10'd6;
    localparam logic [9:0] FUNC_SIE  = 10'd7;
    localparam logic [9:0] FUNC_SIL  = 10'd8;
    localparam logic [9:0] FUNC_SLL  = 10'd9;
    localparam logic [9:0] FUNC_SRL  = 10'd10;
    localparam logic [9:0] FUNC_SRA  = 10'd11;
    localparam logic [9:0] FUNC_SLA  = 10'd12;
    localparam logic [9:0] FUNC_MUL  = 10'd13;
    localparam logic [9:0] FUNC_DIV  = 10'd14;
    localparam logic [9:0] FUNC_MOD  = 10'd15;
    localparam logic [9:0] FUNC_JIE  = 10'd16;
    localparam logic [9:0] FUNC_JIER = 10'd17;
    localparam logic [9:0] FUNC_JIL  = 10'd18;
    localparam logic [9:0] FUNC_JILR = 10'd19;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSie, AluSil,
        AluSll, AluSrl, AluSra, AluSla, AluMul, AluDiv, AluMod, AluNone
    } alu_op_e;

    typedef enum logic [1:0] {StIdle, StMrun, StDrun, StFix} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;    // MUL accumulator / DIV partial remainder
    logic [W-1:0]   opa_q, opa_d;    // MUL multiplicand / DIV dividend-then-quotient
    logic [W-1:0]   opb_q, opb_d;    // MUL multiplier / DIV divisor magnitude
    logic           is_mul_q, is_mul_d;
    logic           is_mod_q, is_mod_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           divz_q, divz_d;
    logic           done_q, done_d;

    alu_op_e        alu_op;
    logic [W-1:0]   single_res;
    logic [W-1:0]   sll_res;
    logic [SH_W-1:0] sh;
    logic [W-1:0]   abs_a, abs_b;
    logic           is_divmod, divz_hit;
    logic [W-1:0]   mul_sum;
    logic [W:0]     rem_sh, rem_diff;
    logic [W-1:0]   fix_res;

    assign sh        = i_b[SH_W-1:0];
    assign sll_res   = i_a << sh;
    assign abs_a     = i_a[W-1] ? (~i_a + 1'b1) : i_a;
    assign abs_b     = i_b[W-1] ? (~i_b + 1'b1) : i_b;
    assign is_divmod = (alu_op == AluDiv) || (alu_op == AluMod);
    assign divz_hit  = is_divmod && (i_b == '0);

    assign mul_sum  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    assign rem_sh   = {acc_q, opa_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, opb_q};

    // Decode opcode/function into an internal operation; jump compares reuse SIE/SIL.
    always_comb begin
        alu_op = AluAdd;
        if (i_op == OP_RTYPE) begin
            case (i_func)
                FUNC_ADD:             alu_op = AluAdd;
                FUNC_SUB:             alu_op = AluSub;
                FUNC_AND:             alu_op = AluAnd;
                FUNC_OR:              alu_op = AluOr;
                FUNC_XOR:             alu_op = AluXor;
                FUNC_NOR:             alu_op = AluNor;
                FUNC_SIE, FUNC_JIE,
                FUNC_JIER:            alu_op = AluSie;
                FUNC_SIL, FUNC_JIL,
                FUNC_JILR:            alu_op = AluSil;
                FUNC_SLL:             alu_op = AluSll;
                FUNC_SRL:             alu_op = AluSrl;
                FUNC_SRA:             alu_op = AluSra;
                FUNC_SLA:             alu_op = AluSla;
                FUNC_MUL:             alu_op = AluMul;
                FUNC_DIV:             alu_op = AluDiv;
                FUNC_MOD:             alu_op = AluMod;
                default:              alu_op = AluNone;
            endcase
        end
    end

    // Single-cycle results, including the divide-by-zero fallbacks.
    always_comb begin
        single_res = '0;
        case (alu_op)
            AluAdd:  single_res = i_a + i_b;
            AluSub:  single_res = i_a - i_b;
            AluAnd:  single_res = i_a & i_b;
            AluOr:   single_res = i_a | i_b;
            AluXor:  single_res = i_a ^ i_b;
            AluNor:  single_res = ~(i_a | i_b);
            AluSie:  single_res = {{(W-1){1'b0}}, i_a == i_b};
            AluSil:  single_res = {{(W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            AluSll:  single_res = sll_res;
            AluSrl:  single_res = i_a >> sh;
            AluSra:  single_res = W'($signed(i_a) >>> sh);
            AluSla:  single_res = {i_a[W-1], sll_res[W-2:0]};
            AluDiv:  single_res = '1;
            AluMod:  single_res = i_a;
            default: single_res = '0;
        endcase
    end

    // Sign fix-up applied in FIX; identity for MUL.
    always_comb begin
        fix_res = acc_q;
        if (!is_mul_q) begin
            if (is_mod_q) begin
                fix_res = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
            end else begin
                fix_res = neg_quo_q ? (~opa_q + 1'b1) : opa_q;
            end
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        is_mul_d  = is_mul_q;
        is_mod_d  = is_mod_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        divz_d    = divz_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    if (alu_op == AluMul) begin
                        acc_d    = '0;
                        opa_d    = i_a;
                        opb_d    = i_b;
                        cnt_d    = CW'(W - 1);
                        is_mul_d = 1'b1;
                        state_d  = StMrun;
                    end else if (is_divmod && !divz_hit) begin
                        acc_d     = '0;
                        opa_d     = abs_a;
                        opb_d     = abs_b;
                        cnt_d     = CW'(W - 1);
                        is_mul_d  = 1'b0;
                        is_mod_d  = (alu_op == AluMod);
                        neg_quo_d = i_a[W-1] ^ i_b[W-1];
                        neg_rem_d = i_a[W-1];
                        state_d   = StDrun;
                    end else begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        divz_d   = divz_hit;
                        done_d   = 1'b1;
                    end
                end
            end
            StMrun: begin
                acc_d = mul_sum;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                if (cnt_q == '0) state_d = StFix;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDrun: begin
                // Restoring step: keep the subtraction only when it does not borrow.
                if (!rem_diff[W]) begin
                    acc_d = rem_diff[W-1:0];
                    opa_d = {opa_q[W-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[W-1:0];
                    opa_d = {opa_q[W-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = StFix;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StFix: begin
                result_d = fix_res;
                zero_d   = (fix_res == '0);
                divz_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            is_mul_q  <= 1'b0;
            is_mod_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            divz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            is_mul_q  <= is_mul_d;
            is_mod_q  <= is_mod_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            divz_q    <= divz_d;
            done_q    <= done_d;
        end
    end

    assign o_busy   = (state_q != StIdle);
    assign o_done   = done_q;
    assign o_result = result_q;
    assign o_zero   = zero_q;
    assign o_divz   = divz_q;

endmodule
